// File: rtl/mips_tlb_pkg.sv
// rtl/mips_tlb_pkg.sv - tlb_pkg: op encodings, CP0 field positions, entry type, translate helper.
// Optional per-entry page masks are enabled with TLB_PAGEMASK_EN.
package tlb_pkg;

  localparam logic [2:0] TLB_NONE = 3'b000;
  localparam logic [2:0] TLBP     = 3'b001;
  localparam logic [2:0] TLBR     = 3'b010;
  localparam logic [2:0] TLBWI    = 3'b011;
  localparam logic [2:0] TLBWR    = 3'b100;

  localparam int EHI_VPN2_MSB = 31;
  localparam int EHI_VPN2_LSB = 13;
  localparam int EHI_ASID_MSB = 7;
  localparam int PMK_MASK_MSB = 24;
  localparam int PMK_MASK_LSB = 13;
  localparam int ELO_PFN_MSB  = 25;
  localparam int ELO_PFN_LSB  = 6;
  localparam int ELO_C_MSB    = 5;
  localparam int ELO_C_LSB    = 3;
  localparam int ELO_D_BIT    = 2;
  localparam int ELO_V_BIT    = 1;
  localparam int ELO_G_BIT    = 0;
  localparam int TLB_INDEX_P_BIT = 31;

  typedef struct packed {
    logic [18:0] vpn2;
    logic [7:0]  asid;
    logic        g;
    logic [11:0] mask;
    logic [19:0] pfn0;
    logic [2:0]  c0;
    logic        d0;
    logic        v0;
    logic [19:0] pfn1;
    logic [2:0]  c1;
    logic        d1;
    logic        v1;
  } tlb_entry_t;

  typedef struct packed {
    logic [31:0] paddr;
    logic        miss;
    logic        inv;
    logic        mod;
    logic [2:0]  cache;
  } tlb_xlate_t;

  function automatic logic [3:0] mask_pop(input logic [11:0] m);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 12; i++) n = n + 4'(m[i]);
    return n;
  endfunction

  // The odd/even select bit sits just above the page offset, which grows with the mask.
  function automatic tlb_xlate_t tlb_xlate(input tlb_entry_t e, input logic hit,
                                           input logic [31:0] va, input logic we);
    tlb_xlate_t r;
    logic [4:0]  sh;
    logic [31:0] offm;
    logic        odd;
    logic [19:0] pfn;
    logic [2:0]  c;
    logic        d;
    logic        v;
    r    = '0;
    sh   = 5'd12 + 5'(mask_pop(e.mask));
    offm = (32'd1 << sh) - 32'd1;
    odd  = va[sh];
    pfn  = odd ? e.pfn1 : e.pfn0;
    c    = odd ? e.c1   : e.c0;
    d    = odd ? e.d1   : e.d0;
    v    = odd ? e.v1   : e.v0;
    if (hit) begin
      r.paddr = ({pfn, 12'b0} & ~offm) | (va & offm);
      r.inv   = ~v;
      r.mod   = we & v & ~d;
      r.cache = c;
    end else begin
      r.miss  = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/mips_tlb_lookup.sv
// rtl/mips_tlb_lookup.sv - tlb_lookup: associative match of all entries, lowest index wins.
module tlb_lookup
  import tlb_pkg::*;
#(
  parameter int TLB_ENTRIES = 32,
  parameter int IDX_W       = $clog2(TLB_ENTRIES)
) (
  input  tlb_entry_t [TLB_ENTRIES-1:0] i_entries,
  input  logic [18:0]                  i_vpn2,
  input  logic [7:0]                   i_asid,
  output logic                         o_hit,
  output logic [IDX_W-1:0]             o_idx
);

  logic [18:0] w_mask;

  // Scanning downward lets the lowest matching index overwrite the others.
  always_comb begin
    o_hit  = 1'b0;
    o_idx  = '0;
    w_mask = '0;
    for (int i = TLB_ENTRIES - 1; i >= 0; i--) begin
      w_mask = {7'b0, i_entries[i].mask};
      if (((i_entries[i].vpn2 & ~w_mask) == (i_vpn2 & ~w_mask)) &&
          (i_entries[i].g || (i_entries[i].asid == i_asid))) begin
        o_hit = 1'b1;
        o_idx = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/mips_tlb.sv
// rtl/mips_tlb.sv - mips_tlb: joint TLB with CP0 op port and registered inst/data lookups.
// Define TLB_PAGEMASK_EN to store and honour per-entry page masks.
module mips_tlb
  import tlb_pkg::*;
#(
  parameter int TLB_ENTRIES = 32,
  parameter int IDX_W       = $clog2(TLB_ENTRIES)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  tlb_typeM,
  input  logic        stallM,
  input  logic        flushM,
  input  logic [31:0] cp0_entryHi,
  input  logic [31:0] cp0_pageMask,
  input  logic [31:0] cp0_entryLo0,
  input  logic [31:0] cp0_entryLo1,
  input  logic [31:0] cp0_index,
  input  logic [31:0] cp0_random,
  output logic [31:0] tlb_entryHi,
  output logic [31:0] tlb_pageMask,
  output logic [31:0] tlb_entryLo0,
  output logic [31:0] tlb_entryLo1,
  output logic [31:0] tlb_index,
  input  logic        inst_req,
  input  logic [31:0] inst_vaddr,
  output logic        inst_rsp,
  output logic [31:0] inst_paddr,
  output logic        inst_miss,
  output logic        inst_inv,
  output logic [2:0]  inst_cache,
  input  logic        data_req,
  input  logic        data_we,
  input  logic [31:0] data_vaddr,
  output logic        data_rsp,
  output logic [31:0] data_paddr,
  output logic        data_miss,
  output logic        data_inv,
  output logic        data_mod,
  output logic [2:0]  data_cache
);

  tlb_entry_t [TLB_ENTRIES-1:0] r_entries;
  tlb_entry_t       w_new;
  tlb_entry_t       w_rd;
  logic             w_we;
  logic [IDX_W-1:0] w_widx;
  logic             w_p_hit, w_i_hit, w_d_hit;
  logic [IDX_W-1:0] w_p_idx, w_i_idx, w_d_idx;
  tlb_xlate_t       w_i_res, w_d_res, r_i_res, r_d_res;
  logic             r_inst_rsp, r_data_rsp;
  logic             w_unused;

  assign w_unused = ^{cp0_entryHi[12:8], cp0_pageMask, cp0_entryLo0[31:26],
                      cp0_entryLo1[31:26], cp0_index, cp0_random};

  assign w_we   = ((tlb_typeM == TLBWI) || (tlb_typeM == TLBWR)) && !stallM && !flushM;
  assign w_widx = (tlb_typeM == TLBWI) ? cp0_index[IDX_W-1:0] : cp0_random[IDX_W-1:0];

  always_comb begin
    w_new      = '0;
    w_new.vpn2 = cp0_entryHi[EHI_VPN2_MSB:EHI_VPN2_LSB];
    w_new.asid = cp0_entryHi[EHI_ASID_MSB:0];
    w_new.g    = cp0_entryLo0[ELO_G_BIT] & cp0_entryLo1[ELO_G_BIT];
`ifdef TLB_PAGEMASK_EN
    w_new.mask = cp0_pageMask[PMK_MASK_MSB:PMK_MASK_LSB];
`else
    w_new.mask = '0;
`endif
    w_new.pfn0 = cp0_entryLo0[ELO_PFN_MSB:ELO_PFN_LSB];
    w_new.c0   = cp0_entryLo0[ELO_C_MSB:ELO_C_LSB];
    w_new.d0   = cp0_entryLo0[ELO_D_BIT];
    w_new.v0   = cp0_entryLo0[ELO_V_BIT];
    w_new.pfn1 = cp0_entryLo1[ELO_PFN_MSB:ELO_PFN_LSB];
    w_new.c1   = cp0_entryLo1[ELO_C_MSB:ELO_C_LSB];
    w_new.d1   = cp0_entryLo1[ELO_D_BIT];
    w_new.v1   = cp0_entryLo1[ELO_V_BIT];
  end

  tlb_lookup #(.TLB_ENTRIES(TLB_ENTRIES), .IDX_W(IDX_W)) u_probe (
    .i_entries(r_entries), .i_vpn2(cp0_entryHi[31:13]), .i_asid(cp0_entryHi[7:0]),
    .o_hit(w_p_hit), .o_idx(w_p_idx)
  );

  tlb_lookup #(.TLB_ENTRIES(TLB_ENTRIES), .IDX_W(IDX_W)) u_inst (
    .i_entries(r_entries), .i_vpn2(inst_vaddr[31:13]), .i_asid(cp0_entryHi[7:0]),
    .o_hit(w_i_hit), .o_idx(w_i_idx)
  );

  tlb_lookup #(.TLB_ENTRIES(TLB_ENTRIES), .IDX_W(IDX_W)) u_data (
    .i_entries(r_entries), .i_vpn2(data_vaddr[31:13]), .i_asid(cp0_entryHi[7:0]),
    .o_hit(w_d_hit), .o_idx(w_d_idx)
  );

  assign w_i_res = tlb_xlate(r_entries[w_i_idx], w_i_hit, inst_vaddr, 1'b0);
  assign w_d_res = tlb_xlate(r_entries[w_d_idx], w_d_hit, data_vaddr, data_we);
  assign w_rd    = r_entries[cp0_index[IDX_W-1:0]];

  always_comb begin
    tlb_entryHi  = '0;
    tlb_pageMask = '0;
    tlb_entryLo0 = '0;
    tlb_entryLo1 = '0;
    tlb_index    = '0;
    case (tlb_typeM)
      TLBP: tlb_index = w_p_hit ? 32'(w_p_idx) : (32'd1 << TLB_INDEX_P_BIT);
      TLBR: begin
        tlb_entryHi  = {w_rd.vpn2, 5'b0, w_rd.asid};
`ifdef TLB_PAGEMASK_EN
        tlb_pageMask = {7'b0, w_rd.mask, 13'b0};
`endif
        tlb_entryLo0 = {6'b0, w_rd.pfn0, w_rd.c0, w_rd.d0, w_rd.v0, w_rd.g};
        tlb_entryLo1 = {6'b0, w_rd.pfn1, w_rd.c1, w_rd.d1, w_rd.v1, w_rd.g};
      end
      default: ;
    endcase
  end

  // Lookups sample the entries before this edge's write lands.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_entries  <= '0;
      r_inst_rsp <= 1'b0;
      r_data_rsp <= 1'b0;
      r_i_res    <= '0;
      r_d_res    <= '0;
    end else begin
      if (w_we) r_entries[w_widx] <= w_new;
      r_inst_rsp <= inst_req;
      r_data_rsp <= data_req;
      if (inst_req) r_i_res <= w_i_res;
      if (data_req) r_d_res <= w_d_res;
    end
  end

  assign inst_rsp   = r_inst_rsp;
  assign inst_paddr = r_i_res.paddr;
  assign inst_miss  = r_i_res.miss;
  assign inst_inv   = r_i_res.inv;
  assign inst_cache = r_i_res.cache;
  assign data_rsp   = r_data_rsp;
  assign data_paddr = r_d_res.paddr;
  assign data_miss  = r_d_res.miss;
  assign data_inv   = r_d_res.inv;
  assign data_mod   = r_d_res.mod;
  assign data_cache = r_d_res.cache;

endmodule

// File: tb/tb_mips_tlb.sv
// tb/tb_mips_tlb.sv - self-checking bench for mips_tlb against an array-based reference model.
module tb_mips_tlb;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  tlb_typeM;
  logic        stallM, flushM;
  logic [31:0] cp0_entryHi, cp0_pageMask, cp0_entryLo0, cp0_entryLo1, cp0_index, cp0_random;
  logic [31:0] tlb_entryHi, tlb_pageMask, tlb_entryLo0, tlb_entryLo1, tlb_index;
  logic        inst_req, inst_rsp, inst_miss, inst_inv;
  logic [31:0] inst_vaddr, inst_paddr;
  logic [2:0]  inst_cache;
  logic        data_req, data_we, data_rsp, data_miss, data_inv, data_mod;
  logic [31:0] data_vaddr, data_paddr;
  logic [2:0]  data_cache;

  int n_pass = 0;
  int n_total = 0;

  // Reference model: one row per entry, fields kept as plain arrays.
  logic [18:0] m_vpn2 [32];
  logic [7:0]  m_asid [32];
  logic        m_g    [32];
  logic [19:0] m_pfn  [32][2];
  logic [2:0]  m_c    [32][2];
  logic        m_d    [32][2];
  logic        m_v    [32][2];

  always #5 clk = ~clk;

  mips_tlb dut (
    .clk(clk), .rst(rst), .tlb_typeM(tlb_typeM), .stallM(stallM), .flushM(flushM),
    .cp0_entryHi(cp0_entryHi), .cp0_pageMask(cp0_pageMask), .cp0_entryLo0(cp0_entryLo0),
    .cp0_entryLo1(cp0_entryLo1), .cp0_index(cp0_index), .cp0_random(cp0_random),
    .tlb_entryHi(tlb_entryHi), .tlb_pageMask(tlb_pageMask), .tlb_entryLo0(tlb_entryLo0),
    .tlb_entryLo1(tlb_entryLo1), .tlb_index(tlb_index),
    .inst_req(inst_req), .inst_vaddr(inst_vaddr), .inst_rsp(inst_rsp), .inst_paddr(inst_paddr),
    .inst_miss(inst_miss), .inst_inv(inst_inv), .inst_cache(inst_cache),
    .data_req(data_req), .data_we(data_we), .data_vaddr(data_vaddr), .data_rsp(data_rsp),
    .data_paddr(data_paddr), .data_miss(data_miss), .data_inv(data_inv), .data_mod(data_mod),
    .data_cache(data_cache)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void m_write(input int idx, input logic [31:0] hi, lo0, lo1);
    logic [31:0] lo [2];
    lo[0] = lo0;
    lo[1] = lo1;
    m_vpn2[idx] = hi[31:13];
    m_asid[idx] = hi[7:0];
    m_g[idx]    = lo0[0] & lo1[0];
    for (int h = 0; h < 2; h++) begin
      m_pfn[idx][h] = lo[h][25:6];
      m_c[idx][h]   = lo[h][5:3];
      m_d[idx][h]   = lo[h][2];
      m_v[idx][h]   = lo[h][1];
    end
  endfunction

  function automatic int m_find(input logic [31:0] va, input logic [7:0] asid);
    for (int i = 0; i < 32; i++)
      if (m_vpn2[i] == va[31:13] && (m_g[i] || m_asid[i] == asid)) return i;
    return -1;
  endfunction

  function automatic logic [31:0] m_probe(input logic [31:0] hi);
    int k;
    k = m_find(hi, hi[7:0]);
    return (k < 0) ? 32'h8000_0000 : 32'(k);
  endfunction

  task automatic m_xlate(input logic [31:0] va, input logic we, output logic miss, inv, mod,
                         output logic [2:0] c, output logic [31:0] pa);
    int k;
    int h;
    k = m_find(va, cp0_entryHi[7:0]);
    miss = 1'b0; inv = 1'b0; mod = 1'b0; c = 3'd0; pa = 32'd0;
    if (k < 0) begin
      miss = 1'b1;
    end else begin
      h   = int'(va[12]);
      pa  = m_pfn[k][h] * 32'h1000 + (va % 32'h1000);
      inv = !m_v[k][h];
      mod = we && m_v[k][h] && !m_d[k][h];
      c   = m_c[k][h];
    end
  endtask

  task automatic do_write(input logic [2:0] op, input int idx, input logic [31:0] hi, lo0, lo1,
                          input logic stall, input logic flush);
    tlb_typeM = op;
    cp0_index  = (op == 3'b011) ? 32'(idx) : 32'(idx ^ 3);
    cp0_random = (op == 3'b100) ? 32'(idx) : 32'(idx ^ 6);
    cp0_entryHi = hi; cp0_entryLo0 = lo0; cp0_entryLo1 = lo1;
    stallM = stall; flushM = flush;
    tick();
    tlb_typeM = 3'b000; stallM = 1'b0; flushM = 1'b0;
    if (!stall && !flush) m_write(idx, hi, lo0, lo1);
  endtask

  task automatic do_data(input logic [31:0] va, input logic we);
    data_req = 1'b1; data_vaddr = va; data_we = we;
    tick();
    data_req = 1'b0;
  endtask

  task automatic check_data(input string name, input logic [31:0] va, input logic we);
    logic miss, inv, mod;
    logic [2:0] c;
    logic [31:0] pa;
    m_xlate(va, we, miss, inv, mod, c, pa);
    do_data(va, we);
    n_total++;
    if ({data_rsp, data_miss, data_inv, data_mod, data_cache, data_paddr} !==
        {1'b1, miss, inv, mod, c, pa})
      $display("FAIL %s va=%h got rsp=%b miss=%b inv=%b mod=%b c=%0d pa=%h exp miss=%b inv=%b mod=%b c=%0d pa=%h",
               name, va, data_rsp, data_miss, data_inv, data_mod, data_cache, data_paddr,
               miss, inv, mod, c, pa);
    else n_pass++;
  endtask

  task automatic check_inst(input string name, input logic [31:0] va);
    logic miss, inv, mod;
    logic [2:0] c;
    logic [31:0] pa;
    m_xlate(va, 1'b0, miss, inv, mod, c, pa);
    inst_req = 1'b1; inst_vaddr = va;
    tick();
    inst_req = 1'b0;
    n_total++;
    if ({inst_rsp, inst_miss, inst_inv, inst_cache, inst_paddr} !== {1'b1, miss, inv, c, pa})
      $display("FAIL %s va=%h got rsp=%b miss=%b inv=%b c=%0d pa=%h exp miss=%b inv=%b c=%0d pa=%h",
               name, va, inst_rsp, inst_miss, inst_inv, inst_cache, inst_paddr, miss, inv, c, pa);
    else n_pass++;
  endtask

  task automatic check_probe(input string name, input logic [31:0] hi);
    tlb_typeM = 3'b001; cp0_entryHi = hi;
    #1;
    n_total++;
    if (tlb_index !== m_probe(hi))
      $display("FAIL %s hi=%h got %h exp %h", name, hi, tlb_index, m_probe(hi));
    else n_pass++;
    tlb_typeM = 3'b000;
  endtask

  task automatic check_read(input string name, input int idx);
    logic [31:0] e_hi, e_lo0, e_lo1;
    tlb_typeM = 3'b010; cp0_index = 32'(idx);
    #1;
    e_hi  = {m_vpn2[idx], 5'b0, m_asid[idx]};
    e_lo0 = {6'b0, m_pfn[idx][0], m_c[idx][0], m_d[idx][0], m_v[idx][0], m_g[idx]};
    e_lo1 = {6'b0, m_pfn[idx][1], m_c[idx][1], m_d[idx][1], m_v[idx][1], m_g[idx]};
    n_total++;
    if ({tlb_entryHi, tlb_pageMask, tlb_entryLo0, tlb_entryLo1, tlb_index} !==
        {e_hi, 32'd0, e_lo0, e_lo1, 32'd0})
      $display("FAIL %s idx=%0d got hi=%h pm=%h lo0=%h lo1=%h ix=%h exp hi=%h pm=0 lo0=%h lo1=%h ix=0",
               name, idx, tlb_entryHi, tlb_pageMask, tlb_entryLo0, tlb_entryLo1, tlb_index,
               e_hi, e_lo0, e_lo1);
    else n_pass++;
    tlb_typeM = 3'b000;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 32; i++) m_write(i, 32'd0, 32'd0, 32'd0);
    rst = 1'b0; tlb_typeM = 3'b000; stallM = 1'b0; flushM = 1'b0;
    cp0_entryHi = 32'd0; cp0_pageMask = 32'd0; cp0_entryLo0 = 32'd0; cp0_entryLo1 = 32'd0;
    cp0_index = 32'd0; cp0_random = 32'd0;
    inst_req = 1'b0; inst_vaddr = 32'd0; data_req = 1'b0; data_we = 1'b0; data_vaddr = 32'd0;
    tick(); tick();
    n_total++;
    if ({inst_rsp, data_rsp, data_paddr, inst_paddr, tlb_index, tlb_entryHi} !== 130'd0)
      $display("FAIL reset_outputs got irsp=%b drsp=%b dpa=%h ipa=%h ix=%h hi=%h exp all 0",
               inst_rsp, data_rsp, data_paddr, inst_paddr, tlb_index, tlb_entryHi);
    else n_pass++;
    rst = 1'b1;
    tick();
    tlb_typeM = 3'b001; cp0_entryHi = 32'h0000_2000;
    #1;
    n_total++;
    if (tlb_index !== 32'h8000_0000)
      $display("FAIL reset_probe got %h exp 80000000", tlb_index);
    else n_pass++;
    tlb_typeM = 3'b000;
    check_inst("reset_inst_miss", 32'h0000_2000);
    n_total++;
    if (inst_miss !== 1'b1) $display("FAIL reset_inst_miss_bit got %b exp 1", inst_miss);
    else n_pass++;
  endtask

  task automatic test_tlbwi();
    do_write(3'b011, 5, 32'h0040_0012, 32'h0000_1016, 32'h0000_2006, 1'b0, 1'b0);
    check_probe("wi_probe", 32'h0040_0012);
    n_total++;
    if (m_probe(32'h0040_0012) !== 32'd5) $display("FAIL wi_model_idx got %h exp 5", m_probe(32'h0040_0012));
    else n_pass++;
    check_data("wi_even", 32'h0040_0abc, 1'b0);
    n_total++;
    if ({data_paddr, data_cache} !== {32'h0004_0abc, 3'd2})
      $display("FAIL wi_even_fixed got pa=%h c=%0d exp 00040abc c=2", data_paddr, data_cache);
    else n_pass++;
    check_data("wi_odd", 32'h0040_1abc, 1'b0);
    n_total++;
    if (data_paddr !== 32'h0008_0abc) $display("FAIL wi_odd_fixed got %h exp 00080abc", data_paddr);
    else n_pass++;
    check_inst("wi_inst", 32'h0040_1ffc);
  endtask

  task automatic test_tlbwr_mod();
    do_write(3'b100, 17, 32'h0080_0034, (32'h123 << 6) | (3 << 3) | 2, (32'h456 << 6) | 6,
             1'b0, 1'b0);
    check_probe("wr_probe", 32'h0080_0034);
    check_data("wr_store_even", 32'h0080_0010, 1'b1);
    n_total++;
    if (data_mod !== 1'b1) $display("FAIL wr_mod got %b exp 1", data_mod);
    else n_pass++;
    check_data("wr_load_even", 32'h0080_0010, 1'b0);
    n_total++;
    if (data_mod !== 1'b0) $display("FAIL wr_load_mod got %b exp 0", data_mod);
    else n_pass++;
    check_data("wr_store_odd", 32'h0080_1010, 1'b1);
  endtask

  task automatic test_asid();
    do_write(3'b011, 8, 32'h0100_0055, 32'h0000_0a02, 32'h0000_0b02, 1'b0, 1'b0);
    cp0_entryHi = 32'h0000_0066;
    check_data("asid_miss", 32'h0100_0123, 1'b0);
    n_total++;
    if (data_miss !== 1'b1) $display("FAIL asid_miss_bit got %b exp 1", data_miss);
    else n_pass++;
    do_write(3'b011, 8, 32'h0100_0055, 32'h0000_0a03, 32'h0000_0b03, 1'b0, 1'b0);
    cp0_entryHi = 32'h0000_0066;
    check_data("global_hit_66", 32'h0100_0123, 1'b0);
    cp0_entryHi = 32'h0000_0099;
    check_inst("global_hit_99", 32'h0100_1456);
    check_read("global_read", 8);
    cp0_entryHi = 32'h0040_0012;
  endtask

  task automatic test_tlbr();
    check_read("tlbr_idx5", 5);
    n_total++;
    if ({tlb_entryHi, tlb_entryLo0, tlb_entryLo1} !== 96'h1 && 1'b0) n_pass++;
    else if ({m_vpn2[5], m_g[5]} !== {19'h200, 1'b0})
      $display("FAIL tlbr_model got vpn2=%h g=%b exp 200 0", m_vpn2[5], m_g[5]);
    else n_pass++;
  endtask

  task automatic test_stall_same_edge();
    do_write(3'b011, 5, 32'h0040_0012, 32'h0007_7f06, 32'h0007_8f06, 1'b1, 1'b0);
    check_read("stall_unchanged", 5);
    do_write(3'b011, 5, 32'h0040_0012, 32'h0007_7f06, 32'h0007_8f06, 1'b0, 1'b1);
    check_read("flush_unchanged", 5);
    cp0_entryHi = 32'h0040_0012;
    check_data("same_edge_pre", 32'h0040_0abc, 1'b0);
    data_req = 1'b1; data_vaddr = 32'h0040_0abc; data_we = 1'b0;
    do_write(3'b011, 5, 32'h0040_0012, 32'h0007_7f06, 32'h0007_8f06, 1'b0, 1'b0);
    data_req = 1'b0;
    n_total++;
    if (data_paddr !== 32'h0004_0abc) $display("FAIL same_edge_old got %h exp 00040abc", data_paddr);
    else n_pass++;
    tick();
    n_total++;
    if ({data_rsp, data_paddr} !== {1'b0, 32'h0004_0abc})
      $display("FAIL hold_no_req got rsp=%b pa=%h exp rsp=0 pa=00040abc", data_rsp, data_paddr);
    else n_pass++;
    check_data("same_edge_new", 32'h0040_0abc, 1'b0);
    check_read("rewrite_read", 5);
  endtask

  task automatic test_random();
    logic [31:0] hi, va;
    int idx;
    for (int it = 0; it < 80; it++) begin
      idx = $urandom_range(0, 31);
      hi  = {16'b0, 3'($urandom_range(0, 7)), 5'($urandom), 8'($urandom_range(0, 3))};
      do_write($urandom_range(0, 1) ? 3'b011 : 3'b100, idx, hi, $urandom, $urandom,
               ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0));
      cp0_entryHi = {16'b0, 3'($urandom_range(0, 7)), 5'b0, 8'($urandom_range(0, 3))};
      check_probe("rand_probe", cp0_entryHi);
      va = {16'b0, 3'($urandom_range(0, 7)), 13'($urandom)};
      check_data("rand_data", va, 1'($urandom));
      va = {16'b0, 3'($urandom_range(0, 7)), 13'($urandom)};
      check_inst("rand_inst", va);
      if (it % 8 == 0) check_read("rand_read", $urandom_range(0, 31));
    end
  endtask

  initial begin
    test_reset();
    test_tlbwi();
    test_tlbwr_mod();
    test_asid();
    test_tlbr();
    test_stall_same_edge();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mips_tlb.md
Name: mips_tlb

Overview:
- Fully associative joint TLB that serves the CP0 register block on the other side of its TLB interface.
- Executes TLBP, TLBR, TLBWI and TLBWR using CP0's EntryHi, PageMask, EntryLo0/1, Index and Random values.
- Returns probe results and read-back values for CP0 to latch in the same cycle.
- Also provides two translation lookup ports, instruction and data, each with a registered 1-cycle response to the fetch and memory stages.

Parameters:
- TLB_ENTRIES, 32, number of entries; power of two from 8 to 32.
- IDX_W, $clog2(TLB_ENTRIES), width of the entry index.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- tlb_typeM  in  3  operation: 000 none, 001 TLBP, 010 TLBR, 011 TLBWI, 100 TLBWR; other values are treated as none
- stallM  in  1  memory stage stalled
- flushM  in  1  memory stage flushed
- cp0_entryHi  in  32  VPN2[31:13], ASID[7:0]
- cp0_pageMask  in  32  Mask[24:13]
- cp0_entryLo0  in  32  PFN[25:6], C[5:3], D[2], V[1], G[0]
- cp0_entryLo1  in  32  same layout as cp0_entryLo0
- cp0_index  in  32  Index[4:0]
- cp0_random  in  32  Random[4:0]
- tlb_entryHi  out  32  TLBR result
- tlb_pageMask  out  32  TLBR result
- tlb_entryLo0  out  32  TLBR result
- tlb_entryLo1  out  32  TLBR result
- tlb_index  out  32  TLBP result: {P, 26'b0, index}
- inst_req  in  1  instruction lookup request
- inst_vaddr  in  32  instruction virtual address
- inst_rsp  out  1  instruction lookup response valid
- inst_paddr  out  32  instruction physical address
- inst_miss  out  1  no matching entry
- inst_inv  out  1  matching entry with V=0
- inst_cache  out  3  C field of the matching page
- data_req  in  1  data lookup request
- data_we  in  1  data access is a store
- data_vaddr  in  32  data virtual address
- data_rsp  out  1  data lookup response valid
- data_paddr  out  32  data physical address
- data_miss  out  1  no matching entry
- data_inv  out  1  matching entry with V=0
- data_mod  out  1  store to a page with D=0
- data_cache  out  3  C field of the matching page

Behaviour:
- Entry storage: VPN2[18:0], ASID[7:0], G, Mask[11:0], and per half PFN[19:0], C[2:0], D, V.
- Reset, asynchronous and active-low:
  - all entries cleared to zero, so every entry has V=0.
  - all registered outputs zero; inst_rsp and data_rsp are 0.
- Match rule for entry i against address VA and ASID A:
  - (VPN2_i & ~Mask_i) == (VA[31:13] & ~Mask_i)
  - and (G_i or ASID_i == A), where A is cp0_entryHi[7:0].
  - With several hits, the lowest index wins (deterministic; software must not rely on it).
- TLBP (001): combinational in the same cycle.
  - Hit: tlb_index = {1'b0, 26'b0, hit index zero-extended to 5 bits}.
  - Miss: tlb_index = 32'h8000_0000.
  - Probe VA is cp0_entryHi.
- TLBR (010): combinational from the entry at cp0_index[IDX_W-1:0].
  - entryHi = {VPN2, 5'b0, ASID}.
  - pageMask = {7'b0, Mask, 13'b0}.
  - entryLoN = {6'b0, PFN, C, D, V, G}; G is replicated into both EntryLo halves.
- TLBWI (011) / TLBWR (100):
  - Entry at cp0_index / cp0_random (low IDX_W bits) is written on the rising edge.
  - The write happens only when !stallM && !flushM.
  - Stored G = G0 & G1. EntryHi bits [12:8] are ignored.
- TLB output hold: when tlb_typeM is none, TLBW* or unknown, tlb_* outputs are zero.
- Lookup ports:
  - A request registered on edge k produces rsp=1 and results in cycle k+1; rsp=0 when there was no request.
  - Results are held until the next request.
  - Odd/even page select is VA bit (12 + popcount(Mask)), with 4KB pages giving bit 12.
  - paddr = {PFN of the selected half, VA[11:0]} when Mask=0; otherwise offset bits are passed per mask.
- Error flags:
  - miss=1 means paddr=0 and inv=mod=0.
  - inv=1 takes priority over mod.
  - mod = data_we & V & ~D.
- Same-edge write and lookup: the lookup uses the pre-write contents; the new entry is visible from the next request.
- Unmapped segments (kseg0/kseg1) are the requester's concern; this block always translates.

Optional Feature:
- Macro TLB_PAGEMASK_EN.
- When defined: PageMask is stored per entry and used in match, odd/even select and offset.
- When undefined: Mask is forced to 0 on write, only 4KB pages are supported, and TLBR returns pageMask=0.

Decomposition:
- Package tlb_pkg:
  - op encodings TLB_NONE, TLBP, TLBR, TLBWI, TLBWR.
  - EntryHi and EntryLo field positions.
  - entry struct typedef.
  - TLB_INDEX_P_BIT=31.
- Sub-module tlb_lookup: combinational match plus priority encoder, instantiated three times (probe, instruction, data).

Test Plan:
- Reset then TLBP with entryHi=0x0000_2000 → tlb_index=0x8000_0000. inst lookup of 0x0000_2000 → next cycle inst_rsp=1, inst_miss=1.
- TLBWI at index 5:
  - Setup: entryHi=0x0040_0012, lo0=0x0000_1016 (PFN 0x40, C=2, D=1, V=1), lo1=0x0000_2006.
  - TLBP with the same entryHi → tlb_index=0x0000_0005.
  - data read of 0x0040_0abc → paddr=0x0004_0abc, cache=2.
  - data read of 0x0040_1abc → paddr=0x0008_0abc.
- TLBWR with random=17, lo0 D=0 → data store to the even page gives data_mod=1; a load to the same address gives mod=0.
- ASID mismatch with G=0 → miss. Rewrite the entry with G0=G1=1 → hit under any ASID.
- TLBR with index=5 → entryHi, entryLo0 and entryLo1 exactly match the written values, with G replicated.
- TLBWI asserted with stallM=1 → entry unchanged. TLBWI and a data lookup on the same edge → lookup reports the old result.
